// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmit serializer among NREQ byte requesters.
// The winner's byte and the line format are captured at accept, so later config edits never reach a frame in flight.
module uart_tx_sched #(
    parameter int NREQ  = 4,
    parameter int DIV_W = 16,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                 app_clk,
    input  logic                 reset_n,
    input  logic                 cfg_en,
    input  logic [1:0]           cfg_data_bits,
    input  logic                 cfg_stop_2,
    input  logic                 cfg_par_en,
    input  logic                 cfg_par_even,
    input  logic [DIV_W-1:0]     cfg_div,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*8-1:0]    req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 txd,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 tx_done
);

    localparam int CW = DIV_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [2:0]        bit_idx;
    logic [IDW-1:0]    last;

    logic [7:0]        byte_q;
    logic [1:0]        nbits_q;
    logic              stop2_q;
    logic              par_en_q;
    logic              par_even_q;
    logic [DIV_W-1:0]  div_q;

    logic [IDW-1:0]    win;
    logic              win_vld;
    logic              grant_ok;
    int                j;
    logic [2:0]        last_idx;
    logic [2:0]        nxt_idx;
    logic [CW-1:0]     reload_cfg;
    logic [CW-1:0]     reload_q;

    // Parity covers only the bits actually sent (nb+5 of them).
    function automatic logic par_bit(input logic [7:0] d, input logic [1:0] nb, input logic even);
        logic [7:0] mask;
        mask = 8'hFF >> (2'd3 - nb);
        return even ? ^(d & mask) : ~^(d & mask);
    endfunction

    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        j       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            j = int'(last) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!win_vld && req_valid[j]) begin
                win_vld = 1'b1;
                win     = IDW'(j);
            end
        end
    end

    assign grant_ok = reset_n && cfg_en && (state == S_IDLE) && win_vld;

    always_comb begin
        req_ready = '0;
        if (grant_ok) req_ready[win] = 1'b1;
    end

    // 2*div+1 is just {div,1}; the extra bit keeps all-ones divisors from wrapping.
    assign reload_cfg = {cfg_div, 1'b1};
    assign reload_q   = {div_q, 1'b1};
    assign last_idx   = {1'b0, nbits_q} + 3'd4;
    assign nxt_idx    = bit_idx + 3'd1;

    always_ff @(posedge app_clk) begin
        if (grant_ok) begin
            byte_q     <= req_data[{win, 3'b000} +: 8];
            nbits_q    <= cfg_data_bits;
            stop2_q    <= cfg_stop_2;
            par_en_q   <= cfg_par_en;
            par_even_q <= cfg_par_even;
            div_q      <= cfg_div;
        end
    end

    always_ff @(posedge app_clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            txd      <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
            grant_id <= '0;
            last     <= IDW'(NREQ - 1);
        end else begin
            tx_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_ok) begin
                        state    <= S_START;
                        cnt      <= reload_cfg;
                        txd      <= 1'b0;
                        busy     <= 1'b1;
                        grant_id <= win;
                        last     <= win;
                    end
                end
                default: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        cnt <= reload_q;
                        case (state)
                            S_START: begin
                                state   <= S_DATA;
                                bit_idx <= 3'd0;
                                txd     <= byte_q[0];
                            end
                            S_DATA: begin
                                if (bit_idx == last_idx) begin
                                    if (par_en_q) begin
                                        state <= S_PARITY;
                                        txd   <= par_bit(byte_q, nbits_q, par_even_q);
                                    end else begin
                                        state <= S_STOP1;
                                        txd   <= 1'b1;
                                    end
                                end else begin
                                    bit_idx <= nxt_idx;
                                    txd     <= byte_q[nxt_idx];
                                end
                            end
                            S_PARITY: begin
                                state <= S_STOP1;
                                txd   <= 1'b1;
                            end
                            S_STOP1: begin
                                txd <= 1'b1;
                                if (stop2_q) begin
                                    state <= S_STOP2;
                                end else begin
                                    state   <= S_IDLE;
                                    busy    <= 1'b0;
                                    tx_done <= 1'b1;
                                    cnt     <= '0;
                                end
                            end
                            S_STOP2: begin
                                state   <= S_IDLE;
                                txd     <= 1'b1;
                                busy    <= 1'b0;
                                tx_done <= 1'b1;
                                cnt     <= '0;
                            end
                            default: begin
                                state <= S_IDLE;
                                txd   <= 1'b1;
                                busy  <= 1'b0;
                                cnt   <= '0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed scenarios plus randomized traffic, checked cycle by cycle
// against a reference that expands each granted frame into a queue of expected line levels.
module tb_uart_tx_sched;

    localparam int NREQ  = 4;
    localparam int DIV_W = 4;
    localparam int IDW   = $clog2(NREQ);

    logic                 app_clk = 1'b0;
    logic                 reset_n;
    logic                 cfg_en;
    logic [1:0]           cfg_data_bits;
    logic                 cfg_stop_2;
    logic                 cfg_par_en;
    logic                 cfg_par_even;
    logic [DIV_W-1:0]     cfg_div;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*8-1:0]    req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 txd;
    logic                 busy;
    logic [IDW-1:0]       grant_id;
    logic                 tx_done;

    always #5 app_clk = ~app_clk;

    uart_tx_sched #(.NREQ(NREQ), .DIV_W(DIV_W)) dut (
        .app_clk       (app_clk),
        .reset_n       (reset_n),
        .cfg_en        (cfg_en),
        .cfg_data_bits (cfg_data_bits),
        .cfg_stop_2    (cfg_stop_2),
        .cfg_par_en    (cfg_par_en),
        .cfg_par_even  (cfg_par_even),
        .cfg_div       (cfg_div),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .txd           (txd),
        .busy          (busy),
        .grant_id      (grant_id),
        .tx_done       (tx_done)
    );

    int   vectors = 0;
    int   miscompares = 0;

    bit   m_busy, m_done, m_txd;
    int   m_gid, m_last;
    bit   wave[$];
    bit   acc;
    int   acc_id;
    bit   auto_clr;
    int   dut_log[$];
    logic cap_t[$];
    logic cap_d[$];
    bit   cap_on;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_busy = 1'b0;
        m_done = 1'b0;
        m_txd  = 1'b1;
        m_gid  = 0;
        m_last = NREQ - 1;
        wave.delete();
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int lst);
        for (int k = 1; k <= NREQ; k++) begin
            int jj;
            jj = (lst + k) % NREQ;
            if (v[jj]) return jj;
        end
        return -1;
    endfunction

    // Expand one frame into per-cycle expected line levels.
    task automatic build(input logic [7:0] b, input int nb, input bit pe, input bit ev,
                         input bit s2, input int div);
        bit bits[$];
        int len;
        int ones;
        len  = 2 * (div + 1);
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            bits.push_back(b[i]);
            ones += int'(b[i]);
        end
        if (pe) bits.push_back(ev ? bit'(ones % 2) : bit'(1 - ones % 2));
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        foreach (bits[i]) repeat (len) wave.push_back(bits[i]);
    endtask

    task automatic tick();
        logic [NREQ-1:0] exp_rdy;
        int w;
        #1;
        exp_rdy = '0;
        w = -1;
        if (reset_n && !m_busy && cfg_en) begin
            w = pick(req_valid, m_last);
            if (w >= 0) exp_rdy[w] = 1'b1;
        end
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        acc = 1'b0;
        if (!reset_n) begin
            m_reset();
        end else if (m_busy) begin
            m_done = 1'b0;
            if (wave.size() > 0) begin
                m_txd = wave.pop_front();
            end else begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_txd  = 1'b1;
            end
        end else begin
            m_done = 1'b0;
            if (w >= 0) begin
                build(req_data[8*w +: 8], int'(cfg_data_bits) + 5, cfg_par_en, cfg_par_even,
                      cfg_stop_2, int'(cfg_div));
                m_txd  = wave.pop_front();
                m_busy = 1'b1;
                m_gid  = w;
                m_last = w;
                acc    = 1'b1;
                acc_id = w;
            end
        end
        @(posedge app_clk);
        @(negedge app_clk);
        chk("txd", 32'(txd), 32'(m_txd));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("tx_done", 32'(tx_done), 32'(m_done));
        chk("grant_id", 32'(grant_id), 32'(m_gid));
        if (acc) begin
            dut_log.push_back(int'(grant_id));
            if (auto_clr) req_valid[acc_id] = 1'b0;
        end
        if (cap_on) begin
            cap_t.push_back(txd);
            cap_d.push_back(tx_done);
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic run_frame(input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_done && n < budget);
        if (!m_done) chk("frame_end_tx_done", 32'(tx_done), 32'd1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        m_reset();
        run(2);
        reset_n = 1'b1;
    endtask

    initial begin
        int nt;
        int r;
        bit exp_bits[11];

        cfg_en = 1'b1; cfg_data_bits = 2'd3; cfg_stop_2 = 1'b0; cfg_par_en = 1'b0;
        cfg_par_even = 1'b0; cfg_div = 4'd3;
        req_valid = 4'b0001; req_data = '0; req_data[7:0] = 8'h55;
        auto_clr = 1'b1; cap_on = 1'b0;
        m_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_done", 32'(tx_done), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        @(negedge app_clk);
        reset_n = 1'b1;

        // Single 8N1 frame of 0x55, 8-cycle bits
        cap_t.delete(); cap_d.delete(); cap_on = 1'b1;
        run_frame(200);
        cap_on = 1'b0;
        for (int k = 0; k < 10; k++) chk($sformatf("sf_bit%0d", k), 32'(cap_t[k*8+4]), 32'(k % 2));
        chk("sf_done_c80", 32'(cap_d[79]), 32'd0);
        chk("sf_done_c81", 32'(cap_d[80]), 32'd1);
        chk("sf_gid", 32'(grant_id), 32'd0);
        run(3);

        // Round-robin with all requesters continuously valid
        do_reset();
        cfg_div = 4'd0;
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        req_valid = 4'hF; auto_clr = 1'b0;
        dut_log.delete();
        repeat (5) run_frame(100);
        req_valid = '0; auto_clr = 1'b1;
        chk("rr_count", 32'(dut_log.size()), 32'd5);
        if (dut_log.size() >= 5) begin
            chk("rr_g0", 32'(dut_log[0]), 32'd0);
            chk("rr_g1", 32'(dut_log[1]), 32'd1);
            chk("rr_g2", 32'(dut_log[2]), 32'd2);
            chk("rr_g3", 32'(dut_log[3]), 32'd3);
            chk("rr_g4", 32'(dut_log[4]), 32'd0);
        end
        run(2);

        // 7E2 then 7O2 of 0x2B from requester 1
        cfg_div = 4'd1; cfg_data_bits = 2'd2; cfg_stop_2 = 1'b1; cfg_par_en = 1'b1; cfg_par_even = 1'b1;
        req_data[15:8] = 8'h2B; req_valid = 4'b0010;
        exp_bits = '{0, 1, 1, 0, 1, 0, 1, 0, 0, 1, 1};
        cap_t.delete(); cap_on = 1'b1;
        run_frame(200);
        cap_on = 1'b0;
        for (int k = 0; k < 11; k++) chk($sformatf("7e2_bit%0d", k), 32'(cap_t[k*4+2]), 32'(exp_bits[k]));
        cfg_par_even = 1'b0; req_valid = 4'b0010;
        cap_t.delete(); cap_on = 1'b1;
        run_frame(200);
        cap_on = 1'b0;
        chk("7o2_parity", 32'(cap_t[8*4+2]), 32'd1);
        chk("7o2_stop2", 32'(cap_t[10*4+2]), 32'd1);
        run(2);

        // Config change during frame 1 must only affect frame 2
        cfg_div = 4'd3; cfg_data_bits = 2'd3; cfg_stop_2 = 1'b0; cfg_par_en = 1'b0;
        req_data[7:0] = 8'h01; req_valid = 4'b0101;
        tick();
        run(20);
        cfg_div = 4'd7; cfg_data_bits = 2'd1;
        run_frame(200);
        cap_t.delete(); cap_on = 1'b1;
        run_frame(300);
        cap_on = 1'b0;
        chk("mid_f2_start_end", 32'(cap_t[15]), 32'd0);
        chk("mid_f2_bit0_beg", 32'(cap_t[16]), 32'd1);
        chk("mid_f2_bit0_end", 32'(cap_t[31]), 32'd1);
        chk("mid_f2_bit1_beg", 32'(cap_t[32]), 32'd0);

        // cfg_en gating with pending requests, then re-enable
        cfg_div = 4'd1; cfg_data_bits = 2'd3;
        req_valid = 4'b0110;
        tick();
        run(5);
        cfg_en = 1'b0;
        run_frame(200);
        run(10);
        req_valid = 4'b0101;
        cfg_en = 1'b1;
        dut_log.delete();
        tick();
        chk("en_regrant_seen", 32'(dut_log.size()), 32'd1);
        if (dut_log.size() > 0) chk("en_regrant_id", 32'(dut_log[0]), 32'd2);

        // Asynchronous reset in the middle of the data bits
        run(10);
        req_valid = 4'b1101;
        #2 reset_n = 1'b0;
        #1;
        chk("arst_txd", 32'(txd), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ready", 32'(req_ready), 32'd0);
        chk("arst_done", 32'(tx_done), 32'd0);
        m_reset();
        run(2);
        reset_n = 1'b1;
        dut_log.delete();
        tick();
        if (dut_log.size() > 0) chk("arst_first_grant", 32'(dut_log[0]), 32'd0);
        else chk("arst_first_grant_busy", 32'(busy), 32'd1);
        run_frame(200);

        // Randomized traffic, config churn and request withdrawal
        auto_clr = 1'b0;
        for (int it = 0; it < 40; it++) begin
            cfg_div       = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3));
            cfg_data_bits = 2'($urandom_range(0, 3));
            cfg_stop_2    = 1'($urandom_range(0, 1));
            cfg_par_en    = 1'($urandom_range(0, 1));
            cfg_par_even  = 1'($urandom_range(0, 1));
            cfg_en        = ($urandom_range(0, 4) != 0);
            for (int q = 0; q < NREQ; q++) begin
                if (!req_valid[q] && $urandom_range(0, 1) == 1) begin
                    req_data[8*q +: 8] = 8'($urandom);
                    req_valid[q] = 1'b1;
                end
            end
            nt = $urandom_range(5, 80);
            for (int t = 0; t < nt; t++) begin
                tick();
                if (acc) begin
                    req_data[8*acc_id +: 8] = 8'($urandom);
                    req_valid[acc_id] = 1'($urandom_range(0, 1));
                end
                if ($urandom_range(0, 15) == 0) begin
                    r = $urandom_range(0, NREQ - 1);
                    if (req_valid[r]) begin
                        req_valid[r] = 1'b0;
                    end else begin
                        req_data[8*r +: 8] = 8'($urandom);
                        req_valid[r] = 1'b1;
                    end
                end
                if ($urandom_range(0, 11) == 0) begin
                    cfg_div       = 4'($urandom_range(0, 15));
                    cfg_data_bits = 2'($urandom_range(0, 3));
                    cfg_par_en    = 1'($urandom_range(0, 1));
                    cfg_stop_2    = 1'($urandom_range(0, 1));
                end
            end
        end
        cfg_en = 1'b0;
        if (m_busy) run_frame(2000);
        run(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
